button_debouncer: RTL and testbench

//   Cleans a raw mechanical push-button/slide-switch input on the board before it reaches the up/down counter.

---
 rtl/button_debouncer_if.sv | 25 ++
 rtl/button_debouncer.sv | 146 ++++++++++++++
 tb/tb_button_debouncer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: the raw button input and the cleaned outputs.
// The master side drives the raw button; the slave side is the debouncer.
interface button_debouncer_if;
  logic btn_raw;
  logic btn_level;
  logic btn_press;
  logic btn_release;
  logic dir_toggle;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  dir_toggle
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output dir_toggle
  );
endinterface

// File: rtl/button_debouncer.sv
// Button debouncer: synchronises a raw bouncing button and accepts a level
// change only after it has held steady for STABLE_CYCLES clocks. Produces a
// clean level, one-cycle press/release pulses and a direction bit that flips
// on every press (reset value 1 = count up).
// Optional feature macro: BTN_AUTO_REPEAT_EN -- while the button stays held,
// btn_press re-fires (and dir_toggle flips) every REPEAT_CYCLES clocks.
module button_debouncer #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W         = 20,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic          clkin,
  input  logic          reset,
  button_debouncer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_in;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_reg, level_next;
  logic             press_reg, press_next;
  logic             release_reg, release_next;
  logic             dir_reg, dir_next;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] rpt_reg, rpt_next;
`else
  // Repeat period has no meaning without the repeat feature.
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_CYCLES;
`endif

  // Shift the asynchronous button through the synchroniser chain.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) sync_reg <= '0;
    else        sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.btn_raw};
  end

  assign sync_in = sync_reg[SYNC_STAGES-1];

  // State, counters and registered outputs.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      dir_reg     <= 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
      rpt_reg     <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      dir_reg     <= dir_next;
`ifdef BTN_AUTO_REPEAT_EN
      rpt_reg     <= rpt_next;
`endif
    end
  end

  // Next-state logic; pulses default low so they last exactly one cycle.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    level_next   = level_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    dir_next     = dir_reg;
`ifdef BTN_AUTO_REPEAT_EN
    rpt_next     = rpt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (sync_in) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync_in) begin
          state_next = IDLE;
        end else if (cnt_reg == CNT_MAX) begin
          state_next = HELD;
          level_next = 1'b1;
          press_next = 1'b1;
          dir_next   = ~dir_reg;
`ifdef BTN_AUTO_REPEAT_EN
          rpt_next   = '0;
`endif
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HELD: begin
        if (!sync_in) begin
          state_next = REL_WAIT;
          cnt_next   = '0;
        end
`ifdef BTN_AUTO_REPEAT_EN
        else if (rpt_reg == RPT_MAX) begin
          press_next = 1'b1;
          dir_next   = ~dir_reg;
          rpt_next   = '0;
        end else begin
          rpt_next = rpt_reg + 1'b1;
        end
`endif
      end
      REL_WAIT: begin
        if (sync_in) begin
          state_next = HELD;
`ifdef BTN_AUTO_REPEAT_EN
          rpt_next   = '0;
`endif
        end else if (cnt_reg == CNT_MAX) begin
          state_next   = IDLE;
          level_next   = 1'b0;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.btn_level   = level_reg;
  assign bus.btn_press   = press_reg;
  assign bus.btn_release = release_reg;
  assign bus.dir_toggle  = dir_reg;

endmodule

// File: tb/tb_button_debouncer.sv
// Testbench for button_debouncer (STABLE_CYCLES=8, SYNC_STAGES=2, REPEAT_CYCLES=20).
// Stimulus pushes expected pulses into a queue; a monitor pops and compares
// each time the DUT emits a press or release pulse.
module tb_button_debouncer;

  logic clkin;
  logic reset;
  int   cyc;
  int   tests;
  int   fails;
  bit   exp_dir;

  typedef struct {
    int cyc;
    bit is_press;
    bit level;
    bit dir;
  } ev_t;

  ev_t exp_q[$];

  button_debouncer_if bus_if ();

  button_debouncer #(
    .STABLE_CYCLES(8),
    .CNT_W(4),
    .SYNC_STAGES(2),
    .REPEAT_CYCLES(20)
  ) dut (
    .clkin(clkin),
    .reset(reset),
    .bus(bus_if)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  always @(posedge clkin) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clkin);
  endtask

  // Raw button went high just before edge t+1; press lands on edge t+11.
  task automatic expect_press(input int t);
    ev_t e;
    exp_dir    = ~exp_dir;
    e.cyc      = t + 11;
    e.is_press = 1'b1;
    e.level    = 1'b1;
    e.dir      = exp_dir;
    exp_q.push_back(e);
    $display("[TB] expect press at edge %0d dir=%0d", e.cyc, e.dir);
  endtask

  task automatic expect_release(input int t);
    ev_t e;
    e.cyc      = t + 11;
    e.is_press = 1'b0;
    e.level    = 1'b0;
    e.dir      = exp_dir;
    exp_q.push_back(e);
    $display("[TB] expect release at edge %0d", e.cyc);
  endtask

  task automatic check_idle_outputs(input string tag, input bit lvl);
    check({tag, "_level"},   int'(bus_if.btn_level),   int'(lvl));
    check({tag, "_press"},   int'(bus_if.btn_press),   0);
    check({tag, "_release"}, int'(bus_if.btn_release), 0);
    check({tag, "_dir"},     int'(bus_if.dir_toggle),  int'(exp_dir));
  endtask

  // Monitor: every emitted pulse must match the head of the queue.
  always @(negedge clkin) begin : monitor
    ev_t e;
    if (reset && (bus_if.btn_press || bus_if.btn_release)) begin
      check("pulse_exclusive", int'(bus_if.btn_press & bus_if.btn_release), 0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got press=%0d release=%0d, expected none (edge %0d)",
                 bus_if.btn_press, bus_if.btn_release, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_edge",  cyc, e.cyc);
        check("pulse_kind",  int'(bus_if.btn_press), int'(e.is_press));
        check("pulse_level", int'(bus_if.btn_level), int'(e.level));
        check("pulse_dir",   int'(bus_if.dir_toggle), int'(e.dir));
        $display("[TB] edge %0d %s level=%0d dir=%0d", cyc,
                 bus_if.btn_press ? "press" : "release", bus_if.btn_level, bus_if.dir_toggle);
      end
    end
  end

  initial begin : stim
    int t;
    cyc   = 0;
    tests = 0;
    fails = 0;
    exp_dir = 1'b1;
    reset = 1'b0;
    bus_if.btn_raw = 1'b0;

    // 1: reset low for 3 cycles, then release.
    tick(3);
    reset = 1'b1;
    check_idle_outputs("reset", 1'b0);

    // 2: clean press then clean release.
    bus_if.btn_raw = 1'b1;
    t = cyc;
    expect_press(t);
    tick(15);
    check_idle_outputs("clean_held", 1'b1);
    bus_if.btn_raw = 1'b0;
    t = cyc;
    expect_release(t);
    tick(15);
    check_idle_outputs("clean_released", 1'b0);

    // 3: 3-cycle bounce for 30 cycles, then steady high.
    for (int k = 0; k < 5; k++) begin
      bus_if.btn_raw = 1'b1;
      tick(3);
      bus_if.btn_raw = 1'b0;
      tick(3);
    end
    bus_if.btn_raw = 1'b1;
    t = cyc;
    expect_press(t);
    tick(15);
    check_idle_outputs("bounce_held", 1'b1);
    bus_if.btn_raw = 1'b0;
    t = cyc;
    expect_release(t);
    tick(15);

    // 4: 5-cycle high glitch while idle, 5-cycle low glitch while held.
    bus_if.btn_raw = 1'b1;
    tick(5);
    bus_if.btn_raw = 1'b0;
    tick(15);
    check_idle_outputs("glitch_idle", 1'b0);
    bus_if.btn_raw = 1'b1;
    t = cyc;
    expect_press(t);
    tick(14);
    bus_if.btn_raw = 1'b0;
    tick(5);
    bus_if.btn_raw = 1'b1;
    tick(10);
    check_idle_outputs("glitch_held", 1'b1);
    bus_if.btn_raw = 1'b0;
    t = cyc;
    expect_release(t);
    tick(15);

    // 5: reset while PRESS_WAIT counter is 5; button stays high through release.
    bus_if.btn_raw = 1'b1;
    tick(8);
    reset = 1'b0;
    exp_dir = 1'b1;
    #1;
    check_idle_outputs("midcount_reset", 1'b0);
    tick(3);
    reset = 1'b1;
    t = cyc;
    expect_press(t);
    tick(15);
    check_idle_outputs("after_reset_held", 1'b1);
    bus_if.btn_raw = 1'b0;
    t = cyc;
    expect_release(t);
    tick(15);

`ifdef BTN_AUTO_REPEAT_EN
    // 6: long hold produces repeats at edges 11, 31, 51, 71.
    bus_if.btn_raw = 1'b1;
    t = cyc;
    expect_press(t);
    expect_press(t + 20);
    expect_press(t + 40);
    expect_press(t + 60);
    tick(75);
    bus_if.btn_raw = 1'b0;
    t = cyc;
    expect_release(t);
    tick(15);
`endif

    tick(5);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
